// File: rtl/uart_tx_dev.sv
//==============================================================================
// Module      : uart_tx_dev
// Description : Memory-mapped 8N1 serial transmitter. The CPU queues bytes
//               into a small TX FIFO through the DATA register. A frame engine
//               shifts them out LSB-first on txd. An interrupt is raised when
//               the queue drains after a frame.
//
// Ports       : clk    - system clock, all state updates on the rising edge
//               reset  - asynchronous, active-low reset
//               Addr   - word address [31:2]; only Addr[3:2] is decoded
//               WE     - write strobe, one cycle per store
//               Din    - write data
//               Dout   - read data, combinational from Addr
//               IRQ    - level interrupt, done_pend & CTRL.IM
//               txd    - serial output, idle high
//
// Registers   : 0x0 CTRL   RW  [0] EN, [1] IM
//               0x4 DIV    RW  [15:0] divisor (bit period = DIV+1 clocks)
//               0x8 DATA   WO  write pushes Din[7:0] into the FIFO
//               0xC STATUS RO  [0] busy, [1] full, [2] empty, [7:4] count,
//                              [8] done_pend, [9] ovf; any write clears 8/9
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_DIV    = 2'd1;
    localparam logic [1:0] OFF_DATA   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [1:0]       ctrl_q,  ctrl_d;
    logic [15:0]      div_q,   div_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q,  wptr_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q,  done_d;
    logic             ovf_q,   ovf_d;

    logic [1:0]       state_q, state_d;
    logic [15:0]      bcnt_q,  bcnt_d;
    logic [2:0]       bidx_q,  bidx_d;
    logic [7:0]       sh_q,    sh_d;
    logic [15:0]      sdiv_q,  sdiv_d;

    //--------------------------------------------------------------------------
    // Bus decode
    //--------------------------------------------------------------------------
    logic [1:0] w_sel;
    logic       w_wr_ctrl;
    logic       w_wr_div;
    logic       w_wr_data;
    logic       w_wr_status;

    assign w_sel       = Addr[3:2];
    assign w_wr_ctrl   = WE && (w_sel == OFF_CTRL);
    assign w_wr_div    = WE && (w_sel == OFF_DIV);
    assign w_wr_data   = WE && (w_sel == OFF_DATA);
    assign w_wr_status = WE && (w_sel == OFF_STATUS);

    //--------------------------------------------------------------------------
    // FIFO flags and handshakes
    //--------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_bit_end;
    logic w_done_set;

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even if the frame engine pops in the same cycle.
    assign w_full    = (count_q == C_DEPTH);
    assign w_empty   = (count_q == '0);
    assign w_push    = w_wr_data && !w_full;
    assign w_drop    = w_wr_data &&  w_full;
    assign w_pop     = (state_q == ST_IDLE) && ctrl_q[0] && !w_empty;
    assign w_bit_end = (bcnt_q == sdiv_q);

    //--------------------------------------------------------------------------
    // Register / FIFO next-state
    //--------------------------------------------------------------------------
    always_comb begin
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        if (w_wr_ctrl) begin
            ctrl_d = Din[1:0];
        end
        if (w_wr_div) begin
            div_d = Din[15:0];
        end

        if (w_push) begin
            wptr_d = (wptr_q == C_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (w_pop) begin
            rptr_d = (rptr_q == C_LAST) ? '0 : rptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A STATUS write clears the sticky flags, but a same-cycle set wins.
        if (w_wr_status) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (w_done_set) begin
            done_d = 1'b1;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Frame engine next-state
    //--------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        bidx_d     = bidx_q;
        sh_d       = sh_q;
        sdiv_d     = sdiv_q;
        w_done_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    // Divisor is latched per frame so DIV writes mid-frame
                    // only take effect on the next frame.
                    sh_d    = mem_q[rptr_q];
                    sdiv_d  = div_q;
                    bcnt_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    bcnt_d  = '0;
                    bidx_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    bcnt_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bidx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    bcnt_d     = '0;
                    state_d    = ST_IDLE;
                    w_done_set = w_empty;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Sequential state
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= '0;
            div_q   <= DIV_RESET;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
            sdiv_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            sdiv_q  <= sdiv_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= Din[7:0];
        end
    end

    //--------------------------------------------------------------------------
    // Read mux and outputs
    //--------------------------------------------------------------------------
    logic [3:0]  w_count4;
    logic [31:0] w_status;

    assign w_count4 = 4'(count_q);
    assign w_status = {22'd0, ovf_q, done_q, w_count4, 1'b0,
                       w_empty, w_full, (state_q != ST_IDLE)};

    always_comb begin
        Dout = '0;
        case (w_sel)
            OFF_CTRL:   Dout = {30'd0, ctrl_q};
            OFF_DIV:    Dout = {16'd0, div_q};
            OFF_DATA:   Dout = '0;
            OFF_STATUS: Dout = w_status;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = done_q & ctrl_q[1];

    // Decoded from state so that reset forces the line high immediately.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = sh_q[0];
            default:  txd = 1'b1;
        endcase
    end

endmodule

`default_nettype wire
